// File: rtl/f2_video_pkg.sv
// Shared F2 video types.
//   rgb888_t        : 8-bit-per-channel colour, as it goes to the DAC
//   PAL_SLOT_VIDEO  : palette slot used by the video lookup (pixel phase 0)
//   PAL_SLOT_CPU    : palette slot used by 68000 accesses (pixel phase 1)
package f2_video_pkg;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb888_t;

    localparam logic PAL_SLOT_VIDEO = 1'b0;
    localparam logic PAL_SLOT_CPU   = 1'b1;

endpackage

// File: rtl/tc0260dar_decode.sv
// Palette word to RGB888 expansion (combinational).
//   i_word : 16-bit palette RAM word
//   o_rgb  : expanded colour
// Build option TC0260DAR_RGB444_EN: when defined, the word is decoded as
// RGBx444 instead of the default xBGR555.
module tc0260dar_decode
    import f2_video_pkg::*;
(
    input  logic [15:0] i_word,
    output rgb888_t     o_rgb
);

    logic w_unused;

`ifdef TC0260DAR_RGB444_EN
    // Nibble replication gives a full-scale 0x00..0xFF range.
    always_comb begin
        o_rgb   = '0;
        o_rgb.r = {i_word[15:12], i_word[15:12]};
        o_rgb.g = {i_word[11:8],  i_word[11:8]};
        o_rgb.b = {i_word[7:4],   i_word[7:4]};
    end
    assign w_unused = ^i_word[3:0];
`else
    // 5-bit channels padded with their own top 3 bits so 0x1F maps to 0xFF.
    always_comb begin
        o_rgb   = '0;
        o_rgb.r = {i_word[4:0],   i_word[4:2]};
        o_rgb.g = {i_word[9:5],   i_word[9:7]};
        o_rgb.b = {i_word[14:10], i_word[14:12]};
    end
    assign w_unused = i_word[15];
`endif

endmodule

// File: rtl/tc0260dar.sv
// TC0260DAR palette / DAC stage.
// Looks up the mixed colour index in external palette RAM and outputs RGB888,
// blanked to black. Palette RAM is time-shared per pixel: the ce_pixel step
// is the VIDEO slot (RA <= IM), the other ce_13m step is the CPU slot.
// Ports:
//   clk, reset          : clock, synchronous active-high reset
//   ce_13m, ce_pixel    : 13.33 MHz enable, pixel enable (every 2nd ce_13m)
//   VA, Din, Dout       : CPU word address, write data, read data
//   LDSn, UDSn, RW      : CPU byte strobes, 1 = read
//   DARCSn, DACKn       : chip select, DTACK
//   IM, HBLOn, VBLOn    : colour index, blanking (active low)
//   RA, RDin, RDout     : palette RAM address, read data, write data
//   RWEUPn, RWELOn      : palette RAM byte write enables
//   R, G, B, blank_n    : colour out, registered blanking aligned with RGB
// Build option TC0260DAR_RGB444_EN selects RGBx444 decode (see decode module).
module tc0260dar
    import f2_video_pkg::*;
#(
    parameter int IDX_W = 14
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             ce_13m,
    input  logic             ce_pixel,
    input  logic [IDX_W:1]   VA,
    input  logic [15:0]      Din,
    output logic [15:0]      Dout,
    input  logic             LDSn,
    input  logic             UDSn,
    input  logic             RW,
    input  logic             DARCSn,
    output logic             DACKn,
    input  logic [IDX_W-1:0] IM,
    input  logic             HBLOn,
    input  logic             VBLOn,
    output logic [IDX_W-1:0] RA,
    input  logic [15:0]      RDin,
    output logic [15:0]      RDout,
    output logic             RWEUPn,
    output logic             RWELOn,
    output logic [7:0]       R,
    output logic [7:0]       G,
    output logic [7:0]       B,
    output logic             blank_n
);

    logic             w_slot;
    rgb888_t          w_rgb;

    logic [IDX_W-1:0] r_ra;
    logic [15:0]      r_dout;
    logic             r_dackn;
    logic             r_weupn;
    logic             r_welon;
    logic             r_pending;
    logic             r_serving;   // CPU slot just drove RA for a request
    logic             r_rd;
    logic             r_cs_prev;
    logic             r_blank;     // blank for the lookup in flight
    logic             r_blank_n;
    rgb888_t          r_rgb;

    // The pixel enable marks the VIDEO step, so the slot can never drift.
    assign w_slot = ce_pixel ? PAL_SLOT_VIDEO : PAL_SLOT_CPU;

    tc0260dar_decode u_decode (
        .i_word (RDin),
        .o_rgb  (w_rgb)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_ra      <= '0;
            r_dout    <= '0;
            r_dackn   <= 1'b1;
            r_weupn   <= 1'b1;
            r_welon   <= 1'b1;
            r_pending <= 1'b0;
            r_serving <= 1'b0;
            r_rd      <= 1'b1;
            // Starting "low" means a CS held across reset is not seen as a
            // new edge, so an interrupted access is dropped.
            r_cs_prev <= 1'b0;
            r_blank   <= 1'b0;
            r_blank_n <= 1'b0;
            r_rgb     <= '0;
        end else if (ce_13m) begin
            r_cs_prev <= DARCSn;
            if (DARCSn)
                r_dackn <= 1'b1;
            if (!DARCSn && r_cs_prev)
                r_pending <= 1'b1;

            if (w_slot == PAL_SLOT_VIDEO) begin
                r_ra    <= IM;
                r_blank <= HBLOn & VBLOn;
                r_weupn <= 1'b1;
                r_welon <= 1'b1;
                if (r_serving) begin
                    if (r_rd)
                        r_dout <= RDin;
                    r_dackn   <= 1'b0;
                    r_pending <= 1'b0;
                    r_serving <= 1'b0;
                end
            end else begin
                // RDin now holds the word addressed by the VIDEO slot.
                r_rgb     <= r_blank ? w_rgb : '0;
                r_blank_n <= r_blank;
                if (r_pending && !r_serving) begin
                    r_ra      <= VA;
                    r_rd      <= RW;
                    r_serving <= 1'b1;
                    if (!RW) begin
                        r_weupn <= UDSn;
                        r_welon <= LDSn;
                    end
                end
            end
        end
    end

    assign RA      = r_ra;
    assign Dout    = r_dout;
    assign DACKn   = r_dackn | DARCSn;
    assign RDout   = Din;
    assign RWEUPn  = r_weupn;
    assign RWELOn  = r_welon;
    assign R       = r_rgb.r;
    assign G       = r_rgb.g;
    assign B       = r_rgb.b;
    assign blank_n = r_blank_n;

endmodule

// File: tb/tb_tc0260dar.sv
// Self-checking bench for tc0260dar with a behavioural palette RAM.
module tb_tc0260dar;

    logic        clk = 1'b0;
    logic        reset;
    logic        ce_13m = 1'b0;
    logic        ce_pixel = 1'b0;
    logic [14:1] VA;
    logic [15:0] Din;
    logic [15:0] Dout;
    logic        LDSn, UDSn, RW, DARCSn, DACKn;
    logic [13:0] IM;
    logic        HBLOn, VBLOn;
    logic [13:0] RA;
    logic [15:0] RDin, RDout;
    logic        RWEUPn, RWELOn;
    logic [7:0]  R, G, B;
    logic        blank_n;

    int n_chk = 0;
    int n_err = 0;
    int n_reads = 0;
    bit preload = 1'b1;
    logic [15:0] mem [0:16383];
    logic [15:0] pal0 [0:7];

    tc0260dar #(.IDX_W(14)) dut (
        .clk(clk), .reset(reset), .ce_13m(ce_13m), .ce_pixel(ce_pixel),
        .VA(VA), .Din(Din), .Dout(Dout), .LDSn(LDSn), .UDSn(UDSn), .RW(RW),
        .DARCSn(DARCSn), .DACKn(DACKn), .IM(IM), .HBLOn(HBLOn), .VBLOn(VBLOn),
        .RA(RA), .RDin(RDin), .RDout(RDout), .RWEUPn(RWEUPn), .RWELOn(RWELOn),
        .R(R), .G(G), .B(B), .blank_n(blank_n)
    );

    initial forever #5 clk = ~clk;

    // ce_13m every second clock, ce_pixel on every second ce_13m.
    initial begin
        int cnt;
        cnt = 0;
        forever begin
            @(negedge clk);
            cnt++;
            ce_13m   = cnt[0];
            ce_pixel = (cnt[1:0] == 2'b01);
        end
    end

    // Palette RAM: asynchronous read, byte writes on ce_13m.
    assign RDin = mem[RA];
    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < 16384; i++) mem[i] <= 16'h0000;
            for (int i = 0; i < 8; i++) mem[i] <= pal0[i];
        end else if (ce_13m) begin
            if (!RWEUPn) mem[RA][15:8] <= RDout[15:8];
            if (!RWELOn) mem[RA][7:0]  <= RDout[7:0];
        end
    end

    function automatic logic [23:0] exp_rgb(input logic [15:0] d);
`ifdef TC0260DAR_RGB444_EN
        return {d[15:12], d[15:12], d[11:8], d[11:8], d[7:4], d[7:4]};
`else
        return {d[4:0], d[4:2], d[9:5], d[9:7], d[14:10], d[14:12]};
`endif
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance to just after the next ce_13m edge; report if it was a pixel edge.
    task automatic step13(output bit pix);
        do @(posedge clk); while (!ce_13m);
        pix = ce_pixel;
        #1;
    endtask

    task automatic sync_pixel();
        bit p;
        do step13(p); while (!p);
    endtask

    task automatic cpu_access(input bit rw, input logic [13:0] addr, input logic [15:0] wd,
                              input bit uds, input bit lds, output logic [15:0] rd);
        int steps, up_lo, lo_lo;
        bit got, p;
        steps = 0; up_lo = 0; lo_lo = 0; got = 0;
        sync_pixel();
        VA = addr; Din = wd; RW = rw; UDSn = uds; LDSn = lds; DARCSn = 1'b0;
        while (!got && steps < 8) begin
            step13(p);
            steps++;
            if (!RWEUPn) up_lo++;
            if (!RWELOn) lo_lo++;
            if (!RWEUPn || !RWELOn) check("wr_ra", {18'd0, RA}, {18'd0, addr});
            if (!DACKn) got = 1'b1;
        end
        check("dack_steps", steps, 4);
        check("we_up_steps", up_lo, (rw || uds) ? 0 : 1);
        check("we_lo_steps", lo_lo, (rw || lds) ? 0 : 1);
        rd = Dout;
        DARCSn = 1'b1; RW = 1'b1; UDSn = 1'b1; LDSn = 1'b1;
        #1;
        check("dack_release", DACKn, 1'b1);
        step13(p);
    endtask

    initial begin
        logic [15:0] rd;
        bit p;
        pal0[0] = 16'h0000; pal0[1] = 16'h001F; pal0[2] = 16'h03E0; pal0[3] = 16'h7C00;
        pal0[4] = 16'h7FFF; pal0[5] = 16'h0421; pal0[6] = 16'h5294; pal0[7] = 16'hFFFF;
        reset = 1'b1; DARCSn = 1'b1; RW = 1'b1; UDSn = 1'b1; LDSn = 1'b1;
        VA = '0; Din = '0; IM = 14'h123; HBLOn = 1'b1; VBLOn = 1'b1;

        repeat (10) @(posedge clk);
        #1;
        preload = 1'b0;
        check("rst_rgb", {R, G, B}, 24'h0);
        check("rst_blank_n", blank_n, 1'b0);
        check("rst_dout", Dout, 16'h0);
        check("rst_dackn", DACKn, 1'b1);
        check("rst_we", {RWEUPn, RWELOn}, 2'b11);
        check("rst_ra", RA, 14'h0);
        reset = 1'b0;

        // First pixel edge after release is a VIDEO slot.
        sync_pixel();
        check("phase_align", RA, 14'h123);

        // Full-word write then video lookup of the same entry.
        cpu_access(1'b0, 14'h010, 16'h7C1F, 1'b0, 1'b0, rd);
        IM = 14'h010;
        sync_pixel();
        step13(p);
`ifdef TC0260DAR_RGB444_EN
        check("vid_7c1f", {R, G, B}, 24'h77CC11);
`else
        check("vid_7c1f", {R, G, B}, 24'hFF00FF);
`endif
        check("vid_blank_n", blank_n, 1'b1);
        sync_pixel();
`ifdef TC0260DAR_RGB444_EN
        check("vid_stable", {R, G, B}, 24'h77CC11);
`else
        check("vid_stable", {R, G, B}, 24'hFF00FF);
`endif

        // Low-byte write, read back the merged word.
        cpu_access(1'b0, 14'h010, 16'hABCD, 1'b1, 1'b0, rd);
        cpu_access(1'b1, 14'h010, 16'h0000, 1'b1, 1'b1, rd);
        check("rd_merged", rd, 16'h7CCD);
        sync_pixel();
        step13(p);
        check("vid_merged", {R, G, B}, exp_rgb(16'h7CCD));

        // Video sequence continues while the CPU reads back-to-back.
        fork
            begin
                for (int k = 0; k < 24; k++) begin
                    sync_pixel();
                    if (k >= 2) check("vid_seq", {R, G, B}, exp_rgb(pal0[(k - 2) % 8]));
                    IM = 14'((k % 8));
                end
            end
            begin
                logic [15:0] r2;
                for (int j = 0; j < 3; j++) begin
                    cpu_access(1'b1, 14'h010, 16'h0000, 1'b1, 1'b1, r2);
                    check("loop_rd", r2, 16'h7CCD);
                    n_reads++;
                end
            end
        join
        check("cpu_reads_done", n_reads, 3);

        // Vertical blank forces black with the same latency.
        IM = 14'h010; VBLOn = 1'b0;
        sync_pixel();
        step13(p);
        check("blank_rgb", {R, G, B}, 24'h0);
        check("blank_n_low", blank_n, 1'b0);
        VBLOn = 1'b1;
        sync_pixel();
        step13(p);
        check("unblank_rgb", {R, G, B}, exp_rgb(16'h7CCD));
        check("unblank_n", blank_n, 1'b1);

        // Reset in the middle of a write drops the access.
        sync_pixel();
        VA = 14'h020; Din = 16'h1234; RW = 1'b0; UDSn = 1'b0; LDSn = 1'b0; DARCSn = 1'b0;
        for (int s = 0; s < 8 && RWELOn; s++) step13(p);
        check("mid_we_low", RWELOn, 1'b0);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("mid_rst_we", {RWEUPn, RWELOn}, 2'b11);
        check("mid_rst_dackn", DACKn, 1'b1);
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (6) step13(p);
        check("mid_dropped", DACKn, 1'b1);
        check("mid_no_we", {RWEUPn, RWELOn}, 2'b11);
        DARCSn = 1'b1; RW = 1'b1; UDSn = 1'b1; LDSn = 1'b1;

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
